// File: rtl/lane_am_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcs_am_pkg
// Description : Shared definitions for the per-lane alignment-marker lock
//               stage: lane/width constants, the 100GBASE-R alignment-marker
//               table and the lock FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pcs_am_pkg;

    localparam int N_LANES    = 20;
    localparam int NB_LANE_ID = 5;
    localparam int NB_BLOCK   = 66;

    // One entry per PCS lane: {M0,M1,M2,M4,M5,M6}. M4..M6 are the bitwise
    // inverse of M0..M2; both halves are stored so the compare is a plain
    // equality against the block payload.
    localparam logic [47:0] AM_TABLE [N_LANES] = '{
        48'hC16821_3E97DE,  // lane 0
        48'h9D718E_628E71,  // lane 1
        48'h594BE8_A6B417,  // lane 2
        48'h4D957B_B26A84,  // lane 3
        48'hF50709_0AF8F6,  // lane 4
        48'hDD14C2_22EB3D,  // lane 5
        48'h9A4A26_65B5D9,  // lane 6
        48'h7B4566_84BA99,  // lane 7
        48'hA02476_5FDB89,  // lane 8
        48'h68C9FB_973604,  // lane 9
        48'hFD6C99_029366,  // lane 10
        48'hB99155_466EAA,  // lane 11
        48'h5CB9B2_A3464D,  // lane 12
        48'h1AF8BD_E50742,  // lane 13
        48'h83C7CA_7C3835,  // lane 14
        48'h3536CD_CAC932,  // lane 15
        48'hC4314C_3BCEB3,  // lane 16
        48'hADD6B7_522948,  // lane 17
        48'h5F662A_A099D5,  // lane 18
        48'hC0F0E5_3F0F1A   // lane 19
    };

    typedef enum logic [2:0] {
        LOCK_INIT = 3'd0,
        FIND_1ST  = 3'd1,
        COUNT_1   = 3'd2,
        COMP_2ND  = 3'd3,
        LOCKED    = 3'd4
    } am_state_e;

endpackage
`default_nettype wire

// File: rtl/lane_am_lock_am_match.sv
`default_nettype none
// ============================================================================
// Module      : am_match
// Description : Combinational 20-way alignment-marker compare. Flags a hit
//               when the sync header is 2'b01 and the M0..M2 / M4..M6 fields
//               equal one lane's table entry; BIP3/BIP7 are ignored.
// Ports       : i_data  - 66-bit block under test
//               o_hit   - block is a valid AM for some lane
//               o_id    - matching lane number (0 when no hit)
// Revision    : 1.0 - initial release
// ============================================================================
module am_match
    import pcs_am_pkg::*;
(
    input  logic [NB_BLOCK-1:0]   i_data,
    output logic                  o_hit,
    output logic [NB_LANE_ID-1:0] o_id
);

    logic [47:0] w_fields;
    logic        w_unused_bip;

    assign w_fields     = {i_data[63:40], i_data[31:8]};
    assign w_unused_bip = ^{i_data[39:32], i_data[7:0]};

    // Table entries are unique, so at most one iteration can match and the
    // loop order carries no priority.
    always_comb begin
        o_hit = 1'b0;
        o_id  = '0;
        if (i_data[65:64] == 2'b01) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (w_fields == AM_TABLE[i]) begin
                    o_hit = 1'b1;
                    o_id  = NB_LANE_ID'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_am_lock.sv
`default_nettype none
// ============================================================================
// Module      : lane_am_lock
// Description : Per-lane alignment-marker lock for the 100GbE PCS receive
//               path. Finds a first AM, confirms it one AM period later,
//               then tracks AM periodicity and drops lock after
//               MAX_INVALID_AM consecutive bad AM slots.
// Ports       : i_clock / i_reset (async, active-low), i_enable (freeze),
//               i_valid, i_block_lock, i_data  - input block stream
//               o_data, o_valid                 - one-cycle delayed copy
//               o_am_lock, o_start_of_lane,
//               o_resync, o_lane_id             - lock status, aligned to o_data
//               o_lock_loss_count               - only with LANE_AM_LOCK_STATS_EN
// Config      : define LANE_AM_LOCK_STATS_EN to add the saturating
//               lock-loss counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_am_lock #(
    parameter int NB_DATA        = 66,
    parameter int AM_PERIOD      = 16384,
    parameter int NB_LANE_ID     = 5,
    parameter int MAX_INVALID_AM = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic                  i_block_lock,
    input  logic [NB_DATA-1:0]    i_data,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_valid,
    output logic                  o_am_lock,
    output logic                  o_start_of_lane,
    output logic                  o_resync,
    output logic [NB_LANE_ID-1:0] o_lane_id
`ifdef LANE_AM_LOCK_STATS_EN
    ,
    output logic [15:0]           o_lock_loss_count
`endif
);
    import pcs_am_pkg::*;

    localparam int CW = $clog2(AM_PERIOD) + 1;
    localparam int IW = $clog2(MAX_INVALID_AM + 1);
    localparam logic [CW-1:0] PERIOD_C   = CW'(AM_PERIOD);
    localparam logic [IW-1:0] LAST_INV_C = IW'(MAX_INVALID_AM - 1);

    logic                  w_hit;
    logic [NB_LANE_ID-1:0] w_hit_id;
    logic                  w_same_id;

    am_state_e             state_q,   state_d;
    logic [CW-1:0]         count_q,   count_d;
    logic [IW-1:0]         invalid_q, invalid_d;
    logic [NB_LANE_ID-1:0] id_q,      id_d;
    logic [NB_DATA-1:0]    data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  am_lock_q, am_lock_d;
    logic                  sol_q,     sol_d;
    logic                  resync_q,  resync_d;
    logic [NB_LANE_ID-1:0] lane_id_q, lane_id_d;

    am_match u_am_match (
        .i_data (i_data),
        .o_hit  (w_hit),
        .o_id   (w_hit_id)
    );

    assign w_same_id = w_hit && (w_hit_id == id_q);

    always_comb begin
        // With enable low every register, pulses included, holds.
        state_d   = state_q;
        count_d   = count_q;
        invalid_d = invalid_q;
        id_d      = id_q;
        data_d    = data_q;
        valid_d   = valid_q;
        am_lock_d = am_lock_q;
        sol_d     = sol_q;
        resync_d  = resync_q;
        lane_id_d = lane_id_q;
        if (i_enable) begin
            data_d   = i_data;
            valid_d  = i_valid;
            sol_d    = 1'b0;
            resync_d = 1'b0;
            if (!i_block_lock) begin
                // Takes priority over an AM-slot failure in the same cycle,
                // so a coincident loss yields one resync and LOCK_INIT.
                state_d   = LOCK_INIT;
                count_d   = '0;
                invalid_d = '0;
                am_lock_d = 1'b0;
                lane_id_d = '0;
                resync_d  = am_lock_q;
            end else begin
                unique case (state_q)
                    LOCK_INIT: begin
                        count_d   = '0;
                        invalid_d = '0;
                        am_lock_d = 1'b0;
                        lane_id_d = '0;
                        state_d   = FIND_1ST;
                    end
                    FIND_1ST: begin
                        if (i_valid && w_hit) begin
                            id_d    = w_hit_id;
                            count_d = CW'(1);
                            state_d = COUNT_1;
                        end
                    end
                    COUNT_1: begin
                        // count==AM_PERIOD means the next valid block is the
                        // expected second AM.
                        if (i_valid) begin
                            count_d = count_q + 1'b1;
                            if (count_d == PERIOD_C) begin
                                state_d = COMP_2ND;
                            end
                        end
                    end
                    COMP_2ND: begin
                        if (i_valid) begin
                            count_d = CW'(1);
                            if (w_same_id) begin
                                am_lock_d = 1'b1;
                                sol_d     = 1'b1;
                                invalid_d = '0;
                                lane_id_d = id_q;
                                state_d   = LOCKED;
                            end else if (w_hit) begin
                                // Different lane: this block becomes the new
                                // first AM.
                                id_d    = w_hit_id;
                                state_d = COUNT_1;
                            end else begin
                                count_d = '0;
                                state_d = FIND_1ST;
                            end
                        end
                    end
                    LOCKED: begin
                        if (i_valid) begin
                            if (count_q == PERIOD_C) begin
                                count_d = CW'(1);
                                if (w_same_id) begin
                                    sol_d     = 1'b1;
                                    invalid_d = '0;
                                end else if (invalid_q >= LAST_INV_C) begin
                                    invalid_d = '0;
                                    am_lock_d = 1'b0;
                                    lane_id_d = '0;
                                    resync_d  = 1'b1;
                                    count_d   = '0;
                                    state_d   = FIND_1ST;
                                end else begin
                                    invalid_d = invalid_q + 1'b1;
                                end
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = LOCK_INIT;
                endcase
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= LOCK_INIT;
            count_q   <= '0;
            invalid_q <= '0;
            id_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            am_lock_q <= 1'b0;
            sol_q     <= 1'b0;
            resync_q  <= 1'b0;
            lane_id_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            invalid_q <= invalid_d;
            id_q      <= id_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            am_lock_q <= am_lock_d;
            sol_q     <= sol_d;
            resync_q  <= resync_d;
            lane_id_q <= lane_id_d;
        end
    end

    assign o_data          = data_q;
    assign o_valid         = valid_q;
    assign o_am_lock       = am_lock_q;
    assign o_start_of_lane = sol_q;
    assign o_resync        = resync_q;
    assign o_lane_id       = lane_id_q;

`ifdef LANE_AM_LOCK_STATS_EN
    logic [15:0] loss_cnt_q, loss_cnt_d;

    // resync_d is only a fresh pulse when enabled; a held pulse counts once.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (i_enable && resync_d && (loss_cnt_q != 16'hFFFF)) begin
            loss_cnt_d = loss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign o_lock_loss_count = loss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lane_am_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_am_lock
// Description : Directed self-checking bench for lane_am_lock with
//               AM_PERIOD=8: lock, lane mismatch, invalid AMs, valid gaps,
//               enable freeze, block-lock drop and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_am_lock;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        valid;
    logic        block_lock;
    logic [65:0] data;
    logic [65:0] o_data;
    logic        o_valid;
    logic        o_am_lock;
    logic        o_sol;
    logic        o_resync;
    logic [4:0]  o_lane_id;
`ifdef LANE_AM_LOCK_STATS_EN
    logic [15:0] o_loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [65:0] IDLE = {2'b10, 64'h1E00_0000_0000_0000};
    localparam logic [65:0] AM0  = {2'b01, 24'hC16821, 8'hA5, 24'h3E97DE, 8'h5A};
    localparam logic [65:0] AM1  = {2'b01, 24'h9D718E, 8'h33, 24'h628E71, 8'hCC};
    // Lane 0 payload with a corrupted M1 byte.
    localparam logic [65:0] BAD  = {2'b01, 24'hC16921, 8'hA5, 24'h3E97DE, 8'h5A};

    lane_am_lock #(
        .NB_DATA        (66),
        .AM_PERIOD      (8),
        .NB_LANE_ID     (5),
        .MAX_INVALID_AM (4)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_enable        (enable),
        .i_valid         (valid),
        .i_block_lock    (block_lock),
        .i_data          (data),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_am_lock       (o_am_lock),
        .o_start_of_lane (o_sol),
        .o_resync        (o_resync),
        .o_lane_id       (o_lane_id)
`ifdef LANE_AM_LOCK_STATS_EN
        ,
        .o_lock_loss_count (o_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one block, clock it, and settle 1 time unit after the edge.
    task automatic blk(input logic [65:0] d, input logic v);
        data  = d;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) blk(IDLE, 1'b1);
    endtask

    task automatic flags(input string tag, input logic lk, input logic sl,
                         input logic rs, input logic [4:0] id);
        chk({tag, "_lock"},   66'(o_am_lock), 66'(lk));
        chk({tag, "_sol"},    66'(o_sol),     66'(sl));
        chk({tag, "_resync"}, 66'(o_resync),  66'(rs));
        chk({tag, "_id"},     66'(o_lane_id), 66'(id));
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        valid      = 1'b1;
        block_lock = 1'b1;
        data       = AM0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data",  o_data, 66'd0);
        chk("rst_valid", 66'(o_valid), 66'd0);
        flags("rst", 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;

        // Lock on lane 0: LOCK_INIT cycle, first AM, 7 blocks, second AM.
        blk(IDLE, 1'b1);
        blk(AM0, 1'b1);
        flags("first_am", 1'b0, 1'b0, 1'b0, 5'd0);
        idle(7);
        chk("pre_lock", 66'(o_am_lock), 66'd0);
        blk(AM0, 1'b1);
        flags("lock0", 1'b1, 1'b1, 1'b0, 5'd0);
        chk("lock0_data", o_data, AM0);
        chk("lock0_valid", 66'(o_valid), 66'd1);
        idle(1);
        flags("lock0_next", 1'b1, 1'b0, 1'b0, 5'd0);
        idle(6);
        blk(AM0, 1'b1);
        flags("slot_good", 1'b1, 1'b1, 1'b0, 5'd0);

        // Three bad slots keep lock; a good AM clears the invalid count.
        for (int k = 0; k < 3; k++) begin
            idle(7);
            blk(BAD, 1'b1);
            flags("bad3a", 1'b1, 1'b0, 1'b0, 5'd0);
        end
        idle(7);
        blk(AM0, 1'b1);
        flags("good_after3", 1'b1, 1'b1, 1'b0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            idle(7);
            blk(BAD, 1'b1);
            flags("bad3b", 1'b1, 1'b0, 1'b0, 5'd0);
        end
        idle(7);
        blk(BAD, 1'b1);
        flags("bad4", 1'b0, 1'b0, 1'b1, 5'd0);
        idle(1);
        flags("bad4_next", 1'b0, 1'b0, 1'b0, 5'd0);
`ifdef LANE_AM_LOCK_STATS_EN
        chk("loss_cnt1", 66'(o_loss_cnt), 66'd1);
`endif

        // Block lock drop while unlocked: no resync.
        block_lock = 1'b0;
        blk(IDLE, 1'b1);
        chk("drop_unlocked", 66'(o_resync), 66'd0);
        block_lock = 1'b1;
        blk(IDLE, 1'b1);

        // Lane mismatch: lane-1 AM restarts the search and then locks.
        blk(AM0, 1'b1);
        idle(7);
        blk(AM1, 1'b1);
        flags("mismatch", 1'b0, 1'b0, 1'b0, 5'd0);
        idle(7);
        blk(AM1, 1'b1);
        flags("lock1", 1'b1, 1'b1, 1'b0, 5'd1);

        // Invalid blocks (even carrying an AM) are not counted nor pulsed.
        idle(3);
        blk(AM1, 1'b0);
        chk("gap_valid", 66'(o_valid), 66'd0);
        chk("gap_sol", 66'(o_sol), 66'd0);
        blk(AM1, 1'b0);
        idle(4);
        blk(AM1, 1'b1);
        flags("gap_slot", 1'b1, 1'b1, 1'b0, 5'd1);

        // Enable low freezes outputs, pulse included.
        enable = 1'b0;
        blk(IDLE, 1'b1);
        blk(IDLE, 1'b1);
        flags("frozen", 1'b1, 1'b1, 1'b0, 5'd1);
        chk("frozen_data", o_data, AM1);
        enable = 1'b1;
        idle(1);
        chk("unfrozen_sol", 66'(o_sol), 66'd0);
        idle(6);
        blk(AM1, 1'b1);
        flags("en_slot", 1'b1, 1'b1, 1'b0, 5'd1);

        // Block lock drop while locked: one resync pulse, relock on lane 0.
        block_lock = 1'b0;
        blk(IDLE, 1'b1);
        flags("drop", 1'b0, 1'b0, 1'b1, 5'd0);
        block_lock = 1'b1;
        blk(IDLE, 1'b1);
        chk("drop_next", 66'(o_resync), 66'd0);
        blk(AM0, 1'b1);
        idle(7);
        blk(AM0, 1'b1);
        flags("relock", 1'b1, 1'b1, 1'b0, 5'd0);
`ifdef LANE_AM_LOCK_STATS_EN
        chk("loss_cnt2", 66'(o_loss_cnt), 66'd2);
`endif

        // Asynchronous reset mid-lock.
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("arst_data", o_data, 66'd0);
        flags("arst", 1'b0, 1'b0, 1'b0, 5'd0);
`ifdef LANE_AM_LOCK_STATS_EN
        chk("arst_cnt", 66'(o_loss_cnt), 66'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        flags("post_rst", 1'b0, 1'b0, 1'b0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
